// File: rtl/inst_cache_pkg.sv
// Shared encodings for the instruction cache: reset level, valid flag,
// zero word and refill FSM states.
package inst_cache_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic              RST_ACTIVE = 1'b1;
  localparam logic              VALID      = 1'b1;
  localparam logic              INVALID    = 1'b0;
  localparam logic [WORD_W-1:0] ZERO_WORD  = WORD_W'(0);

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped tag/data/valid storage: combinational read port,
// synchronous write port, synchronous clear of every valid bit.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 26
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [WORD_W-1:0] wr_data
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES];

  // Clear wins over write so a flush never leaves a freshly written line valid.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= {LINES{INVALID}};
    end else if (wr_en) begin
      valid[wr_idx] <= VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped one-word-per-line instruction cache with zero-latency hits
// and a single outstanding refill to backing memory.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        instValid,
  output logic        stall,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  state_t            state, state_nx;
  logic              mem_req_nx;
  logic [31:0]       mem_addr_nx;
  logic              discard, discard_nx;
  logic              wr_en;
  logic              hit_c;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_data;
  logic              unused_pc;

  // Byte offset within the word is irrelevant to a word-granular cache.
  assign unused_pc = &{1'b0, pc[1:0]};

  inst_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .clr      ((rst == RST_ACTIVE) | flush),
    .rd_idx   (pc[IDX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (memAddr[IDX_W+1:2]),
    .wr_tag   (memAddr[31:IDX_W+2]),
    .wr_data  (memData)
  );

  // A flush in the same cycle invalidates the line being looked up.
  assign hit_c = ce & (state == IDLE) & ~flush & (rd_valid == VALID)
               & (rd_tag == pc[31:IDX_W+2]);

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state   <= IDLE;
      memReq  <= 1'b0;
      memAddr <= 32'h0;
      discard <= 1'b0;
    end else begin
      state   <= state_nx;
      memReq  <= mem_req_nx;
      memAddr <= mem_addr_nx;
      discard <= discard_nx;
    end
  end

  // discard remembers a flush seen mid-refill so the returning word is dropped.
  always_comb begin
    state_nx    = state;
    mem_req_nx  = memReq;
    mem_addr_nx = memAddr;
    discard_nx  = discard;
    wr_en       = 1'b0;
    inst        = ZERO_WORD;
    instValid   = 1'b0;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        if (ce) begin
          if (hit_c) begin
            inst      = rd_data;
            instValid = 1'b1;
          end else begin
            stall       = 1'b1;
            state_nx    = REFILL;
            mem_req_nx  = 1'b1;
            mem_addr_nx = {pc[31:2], 2'b00};
            discard_nx  = 1'b0;
          end
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (flush) discard_nx = 1'b1;
        if (memAck) begin
          wr_en      = ~flush & ~discard;
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          discard_nx = 1'b0;
        end
      end
    endcase
    if (rst == RST_ACTIVE) begin
      inst      = ZERO_WORD;
      instValid = 1'b0;
      stall     = 1'b0;
      wr_en     = 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: expected instruction words are queued when
// a fetch is issued and popped when the cache delivers the word.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        instValid;
  logic        stall;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] SENTINEL = 32'hBAD0_BAD0;

  inst_cache #(.LINES(16), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pc        (pc),
    .flush     (flush),
    .inst      (inst),
    .instValid (instValid),
    .stall     (stall),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memAck    (memAck),
    .memData   (memData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0001;
  endfunction

  // Fetch one word, acting as backing memory on a miss (ack one cycle after memReq).
  task automatic do_fetch(input logic [31:0] a, output logic missed, output logic [31:0] got);
    ce = 1'b1; pc = a;
    @(negedge clk);
    if (instValid && !stall) begin
      missed = 1'b0;
      got    = inst;
      @(posedge clk); #1;
    end else begin
      missed = 1'b1;
      @(posedge clk); #1;
      memAck = 1'b1; memData = model(a);
      @(posedge clk); #1;
      memAck = 1'b0; memData = 32'h0;
      @(negedge clk);
      got = (instValid && !stall) ? inst : SENTINEL;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; pc = 32'h0; flush = 1'b0; memAck = 1'b0; memData = 32'h0;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0b want 0", stall); end
    n_cmp++; if (instValid !== 1'b0) begin n_bad++; $display("FAIL rst_instValid: got %0b want 0", instValid); end
    n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h want 0", inst); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL rst_memReq: got %0b want 0", memReq); end
    n_cmp++; if (memAddr !== 32'h0) begin n_bad++; $display("FAIL rst_memAddr: got %h want 0", memAddr); end
    rst = 1'b0; ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_first_fill();
    ce = 1'b1; pc = 32'h0;
    exp_q.push_back(32'h2001_0005);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fill_stall: got %0b want 1", stall); end
    n_cmp++; if (instValid !== 1'b0) begin n_bad++; $display("FAIL fill_miss_valid: got %0b want 0", instValid); end
    n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL fill_miss_inst: got %h want 0", inst); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (memReq !== 1'b1) begin n_bad++; $display("FAIL fill_memReq: got %0b want 1", memReq); end
    n_cmp++; if (memAddr !== 32'h0) begin n_bad++; $display("FAIL fill_memAddr: got %h want 0", memAddr); end
    memAck = 1'b1; memData = 32'h2001_0005;
    @(posedge clk); #1;
    memAck = 1'b0; memData = 32'h0;
    @(negedge clk);
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL fill_memReq_drop: got %0b want 0", memReq); end
    n_cmp++; if (instValid !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL fill_hit: got valid=%0b stall=%0b want 1/0", instValid, stall); end
    n_cmp++; if (inst !== exp_q[0]) begin n_bad++; $display("FAIL fill_inst: got %h want %h", inst, exp_q[0]); end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic test_eviction();
    logic [31:0] addrs [5] = '{32'h04, 32'h44, 32'h04, 32'h04, 32'h00};
    logic        miss_e[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic m;
    logic [31:0] g;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(addrs[i] == 32'h0 ? 32'h2001_0005 : model(addrs[i]));
      do_fetch(addrs[i], m, g);
      n_cmp++; if (m !== miss_e[i]) begin n_bad++; $display("FAIL evict_miss[%0d]: got %0b want %0b", i, m, miss_e[i]); end
      n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL evict_inst[%0d]: got %h want %h", i, g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_delayed_ack();
    ce = 1'b1; pc = 32'h0C;
    exp_q.push_back(model(32'h0C));
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL dly_first_stall: got %0b want 1", stall); end
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      if (c >= 1 && c <= 3) ce = 1'b0; else ce = 1'b1;
      @(negedge clk);
      n_cmp++; if (memReq !== 1'b1) begin n_bad++; $display("FAIL dly_memReq[%0d]: got %0b want 1", c, memReq); end
      n_cmp++; if (memAddr !== 32'h0C) begin n_bad++; $display("FAIL dly_memAddr[%0d]: got %h want 0000000c", c, memAddr); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL dly_stall[%0d]: got %0b want 1", c, stall); end
      @(posedge clk); #1;
    end
    ce = 1'b1; memAck = 1'b1; memData = model(32'h0C);
    @(posedge clk); #1;
    memAck = 1'b0; memData = 32'h0;
    @(negedge clk);
    n_cmp++; if (!(instValid === 1'b1 && inst === exp_q[0])) begin n_bad++; $display("FAIL dly_hit: got valid=%0b inst=%h want 1/%h", instValid, inst, exp_q[0]); end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [31:0] addrs [4] = '{32'h08, 32'h00, 32'h04, 32'h0C};
    logic m;
    logic [31:0] g;
    // flush coincident with memAck
    ce = 1'b1; pc = 32'h08;
    @(posedge clk); #1;
    memAck = 1'b1; flush = 1'b1; memData = model(32'h08);
    @(posedge clk); #1;
    memAck = 1'b0; flush = 1'b0; memData = 32'h0; ce = 1'b0;
    @(negedge clk);
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL flush_ack_memReq: got %0b want 0", memReq); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(addrs[i]));
      do_fetch(addrs[i], m, g);
      n_cmp++; if (m !== 1'b1) begin n_bad++; $display("FAIL flush_miss[%0d]: got %0b want 1", i, m); end
      n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL flush_inst[%0d]: got %h want %h", i, g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    // flush mid-refill, ack one cycle later
    ce = 1'b1; pc = 32'h10;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; memAck = 1'b1; memData = model(32'h10);
    @(posedge clk); #1;
    memAck = 1'b0; memData = 32'h0; ce = 1'b0;
    @(negedge clk);
    n_cmp++; if (memReq !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL flush_mid_idle: got memReq=%0b stall=%0b want 0/0", memReq, stall); end
    @(posedge clk); #1;
    exp_q.push_back(model(32'h10));
    do_fetch(32'h10, m, g);
    n_cmp++; if (m !== 1'b1) begin n_bad++; $display("FAIL flush_mid_miss: got %0b want 1", m); end
    n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL flush_mid_inst: got %h want %h", g, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_rst_mid_refill();
    logic [31:0] addrs [2] = '{32'h00, 32'h10};
    logic m;
    logic [31:0] g;
    ce = 1'b1; pc = 32'h14;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0 || instValid !== 1'b0) begin n_bad++; $display("FAIL rstmid_outs: got stall=%0b valid=%0b want 0/0", stall, instValid); end
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b0; memAck = 1'b1; memData = model(32'h14);
    @(posedge clk); #1;
    memAck = 1'b0; memData = 32'h0;
    @(negedge clk);
    n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL rstmid_memReq: got %0b want 0", memReq); end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(addrs[i]));
      do_fetch(addrs[i], m, g);
      n_cmp++; if (m !== 1'b1) begin n_bad++; $display("FAIL rstmid_miss[%0d]: got %0b want 1", i, m); end
      n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_inst[%0d]: got %h want %h", i, g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_ce_low();
    ce = 1'b0; pc = 32'h0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin memAck = 1'b1; memData = 32'hFFFF_FFFF; end
      else begin memAck = 1'b0; memData = 32'h0; end
      @(negedge clk);
      n_cmp++; if (instValid !== 1'b0 || stall !== 1'b0 || inst !== 32'h0) begin n_bad++; $display("FAIL celow_outs[%0d]: got valid=%0b stall=%0b inst=%h want 0/0/0", c, instValid, stall, inst); end
      n_cmp++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL celow_memReq[%0d]: got %0b want 0", c, memReq); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4] = '{32'h00, 32'h10, 32'h00, 32'h10};
    logic m;
    logic [31:0] g;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(addrs[i]));
      do_fetch(addrs[i], m, g);
      n_cmp++; if (m !== 1'b0) begin n_bad++; $display("FAIL b2b_miss[%0d]: got %0b want 0", i, m); end
      n_cmp++; if (g !== exp_q[0]) begin n_bad++; $display("FAIL b2b_inst[%0d]: got %h want %h", i, g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_first_fill();
    test_eviction();
    test_delayed_ack();
    test_flush();
    test_rst_mid_refill();
    test_ce_low();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
